// File: rtl/hex_debug_display.sv
// -----------------------------------------------------------------------------
// hex_debug_display
//
// Purpose:
//   Board-level debug readout. Selects one of NUM_CH DATA_W-bit debug channels
//   and shows it on DATA_W/4 active-low seven-segment digits. The channel is
//   chosen from switches (manual) or rotates on a fixed period (auto). A
//   debounced, active-low push-button toggles a frozen snapshot of all
//   channels, so related values (e.g. register pairs) stay coherent while
//   being read off the board.
//
// Parameters:
//   NUM_CH       number of input channels (>= 2)
//   DATA_W       channel width, multiple of 4; DIGITS = DATA_W/4
//   SCROLL_CYC   clk cycles per channel in auto mode (>= 2)
//   DEBOUNCE_CYC consecutive stable samples to accept a button level (>= 2)
//
// Ports:
//   clk         the only clock
//   rst_n       asynchronous active-low reset
//   ch_data     channel k at [k*DATA_W +: DATA_W]
//   sel         manual channel select (asynchronous switches)
//   auto_en     1 = auto-rotate (synchronous)
//   freeze_btn  raw push-button, pressed = 0 (asynchronous)
//   seg_n       digit d at [d*7 +: 7], bit order g..a, active-low; digit 0 = LS nibble
//   cur_ch      channel currently displayed
//   frozen      1 while the snapshot is displayed
//
// Build option:
//   HEXDISP_LZB_EN  when defined, digits above the most-significant non-zero
//                   nibble are blanked (digit 0 always shown). Same register
//                   stage, so latency does not change.
// -----------------------------------------------------------------------------
module hex_debug_display #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 16,
  parameter int SCROLL_CYC   = 4_190_000,
  parameter int DEBOUNCE_CYC = 41_900
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH*DATA_W-1:0]      ch_data,
  input  logic [$clog2(NUM_CH)-1:0]     sel,
  input  logic                          auto_en,
  input  logic                          freeze_btn,
  output logic [(DATA_W/4)*7-1:0]       seg_n,
  output logic [$clog2(NUM_CH)-1:0]     cur_ch,
  output logic                          frozen
);

  localparam int DIGITS = DATA_W / 4;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int SC_W   = $clog2(SCROLL_CYC);
  localparam int DB_W   = $clog2(DEBOUNCE_CYC);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_CYC - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  // Standard hex font, active-low, bit order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. Both reset to 1 so a released button does not look
  // like a press coming out of reset.
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0] r_sel_meta;
  logic [CH_W-1:0] r_sel_sync;
  logic            r_btn_meta;
  logic            r_btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_meta <= '1;
      r_sel_sync <= '1;
      r_btn_meta <= 1'b1;
      r_btn_sync <= 1'b1;
    end else begin
      r_sel_meta <= sel;
      r_sel_sync <= r_sel_meta;
      r_btn_meta <= freeze_btn;
      r_btn_sync <= r_btn_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce. The counter runs only while the synchronised button disagrees
  // with the accepted level; DEBOUNCE_CYC disagreeing samples in a row flip
  // the accepted level. A 1->0 flip registers a one-cycle press pulse.
  // ---------------------------------------------------------------------------
  logic            r_db_state;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press;
  logic            w_db_differ;
  logic            w_db_flip;

  assign w_db_differ = (r_btn_sync != r_db_state);
  assign w_db_flip   = w_db_differ && (r_db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_state <= 1'b1;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      if (!w_db_differ) begin
        r_db_cnt <= '0;
      end else if (w_db_flip) begin
        r_db_cnt   <= '0;
        r_db_state <= ~r_db_state;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      // Accepted level currently 1 and flipping -> press. Releases are silent.
      r_press <= w_db_flip && r_db_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Freeze toggle and snapshot. Entering the frozen state captures every
  // channel in the same cycle so the snapshot is coherent across channels.
  // ---------------------------------------------------------------------------
  logic              r_frozen;
  logic [DATA_W-1:0] r_snap [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frozen <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_snap[k] <= '0;
      end
    end else if (r_press) begin
      r_frozen <= ~r_frozen;
      if (!r_frozen) begin
        for (int k = 0; k < NUM_CH; k++) begin
          r_snap[k] <= ch_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel selection. Out-of-range switch codes clamp to the last channel;
  // when NUM_CH fills the select width there is nothing to clamp.
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0] w_sel_clamped;

  generate
    if (NUM_CH == (1 << CH_W)) begin : g_no_clamp
      assign w_sel_clamped = r_sel_sync;
    end else begin : g_clamp
      assign w_sel_clamped = (r_sel_sync > LAST_CH) ? LAST_CH : r_sel_sync;
    end
  endgenerate

  logic [SC_W-1:0] r_scroll_cnt;
  logic [CH_W-1:0] r_cur_ch;
  logic [CH_W-1:0] w_next_ch;
  logic            w_scroll_wrap;

  assign w_next_ch     = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + 1'b1;
  assign w_scroll_wrap = (r_scroll_cnt == SC_LAST);

  // Auto mode starts counting from the channel already shown; the counter is
  // parked at 0 in manual mode so every auto period begins cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scroll_cnt <= '0;
      r_cur_ch     <= '0;
    end else if (auto_en) begin
      if (w_scroll_wrap) begin
        r_scroll_cnt <= '0;
        r_cur_ch     <= w_next_ch;
      end else begin
        r_scroll_cnt <= r_scroll_cnt + 1'b1;
      end
    end else begin
      r_scroll_cnt <= '0;
      r_cur_ch     <= w_sel_clamped;
    end
  end

  // ---------------------------------------------------------------------------
  // Display source mux, decode and (optional) leading-zero blanking, all
  // feeding one output register.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]   w_src;
  logic [DIGITS*7-1:0] w_seg_next;
  logic [DIGITS*7-1:0] r_seg;

  always_comb begin
    w_src = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_cur_ch == CH_W'(k)) begin
        w_src = r_frozen ? r_snap[k] : ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef HEXDISP_LZB_EN
  logic w_seen_nz;

  // Walk from the top digit down; once a non-zero nibble is seen every lower
  // digit is shown. Digit 0 is never blanked so zero reads as "0".
  always_comb begin
    w_seg_next = '1;
    w_seen_nz  = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (w_src[d*4 +: 4] != 4'h0) begin
        w_seen_nz = 1'b1;
      end
      if (w_seen_nz || (d == 0)) begin
        w_seg_next[d*7 +: 7] = hex7(w_src[d*4 +: 4]);
      end else begin
        w_seg_next[d*7 +: 7] = 7'h7F;
      end
    end
  end
`else
  always_comb begin
    w_seg_next = '1;
    for (int d = 0; d < DIGITS; d++) begin
      w_seg_next[d*7 +: 7] = hex7(w_src[d*4 +: 4]);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '1;
    end else begin
      r_seg <= w_seg_next;
    end
  end

  assign seg_n  = r_seg;
  assign cur_ch = r_cur_ch;
  assign frozen = r_frozen;

endmodule

// File: tb/tb_hex_debug_display.sv
`timescale 1ns/1ps
module tb_hex_debug_display;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int SC  = 4;
  localparam int DB  = 4;
  localparam int DIG = DW / 4;
  localparam int CHW = 2;

`ifdef HEXDISP_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // Hex font from the display definition: index = nibble, g..a active-low.
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCH*DW-1:0] ch_data;
  logic [CHW-1:0]    sel;
  logic              auto_en;
  logic              freeze_btn;
  logic [DIG*7-1:0]  seg_n;
  logic [CHW-1:0]    cur_ch;
  logic              frozen;

  logic [3*DW-1:0]   ch_data3;
  logic [DIG*7-1:0]  seg_n3;
  logic [1:0]        cur_ch3;
  logic              frozen3;

  assign ch_data3 = ch_data[3*DW-1:0];

  hex_debug_display #(
    .NUM_CH(NCH), .DATA_W(DW), .SCROLL_CYC(SC), .DEBOUNCE_CYC(DB)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .sel(sel),
    .auto_en(auto_en), .freeze_btn(freeze_btn),
    .seg_n(seg_n), .cur_ch(cur_ch), .frozen(frozen)
  );

  // Three-channel instance for the select clamp.
  hex_debug_display #(
    .NUM_CH(3), .DATA_W(DW), .SCROLL_CYC(SC), .DEBOUNCE_CYC(DB)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data3), .sel(sel),
    .auto_en(1'b0), .freeze_btn(1'b1),
    .seg_n(seg_n3), .cur_ch(cur_ch3), .frozen(frozen3)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected digits for a value: font lookup per nibble, leading digits blank
  // when blanking is built in and nothing non-zero remains at or above them.
  function automatic logic [DIG*7-1:0] ref_seg(input logic [DW-1:0] v);
    logic [DIG*7-1:0] r;
    logic [DW-1:0] upper;
    for (int d = 0; d < DIG; d++) begin
      upper = v >> (4 * d);
      r[d*7 +: 7] = FONT[upper[3:0]];
      if (LZB && d != 0 && upper == '0) r[d*7 +: 7] = 7'h7F;
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [DW-1:0]    m_snap [NCH];
  int               m_cur;
  bit               m_frozen;
  logic [DIG*7-1:0] m_seg;
  logic [CHW-1:0]   sel_q [$];   // sel samples, newest first
  bit               btn_q [$];   // button samples, newest first
  bit               m_acc;       // accepted button level
  int               m_run;       // consecutive samples differing from m_acc
  bit               m_pend;      // press accepted, freeze toggles next edge
  bit               m_in_auto;
  int               m_base;
  int               m_n;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) m_snap[k] = '0;
    m_cur = 0; m_frozen = 0; m_seg = '1;
    sel_q.delete(); btn_q.delete();
    for (int i = 0; i < 3; i++) begin
      sel_q.push_front('1);
      btn_q.push_front(1'b1);
    end
    m_acc = 1; m_run = 0; m_pend = 0; m_in_auto = 0; m_base = 0; m_n = 0;
  endtask

  // One clock edge of the observable behaviour, with inputs as sampled there.
  task automatic model_step();
    logic [DW-1:0] src;
    int s;
    bit sb;
    src   = m_frozen ? m_snap[m_cur] : ch_data[m_cur*DW +: DW];
    m_seg = ref_seg(src);
    if (m_pend) begin
      if (!m_frozen) for (int k = 0; k < NCH; k++) m_snap[k] = ch_data[k*DW +: DW];
      m_frozen = !m_frozen;
      m_pend = 0;
    end
    sel_q.push_front(sel);
    btn_q.push_front(freeze_btn);
    if (sel_q.size() > 3) void'(sel_q.pop_back());
    if (btn_q.size() > 3) void'(btn_q.pop_back());
    // The sample two edges old is what the design sees after synchronising.
    sb = btn_q[2];
    if (sb == m_acc) m_run = 0;
    else begin
      m_run++;
      if (m_run == DB) begin
        m_acc = sb;
        m_run = 0;
        m_pend = !m_acc;
      end
    end
    if (auto_en) begin
      if (!m_in_auto) begin
        m_in_auto = 1; m_base = m_cur; m_n = 0;
      end
      m_n++;
      m_cur = (m_base + m_n / SC) % NCH;
    end else begin
      m_in_auto = 0;
      s = int'(sel_q[2]);
      m_cur = (s > NCH - 1) ? NCH - 1 : s;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_eq("cur_ch", cur_ch, m_cur);
    check_eq("frozen", frozen, m_frozen);
    check_eq("seg_n", seg_n, m_seg);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_seg", seg_n, {DIG*7{1'b1}});
    check_eq("async_rst_cur", cur_ch, 0);
    check_eq("async_rst_frz", frozen, 0);
    cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] lead;
    int btn_hold;

    rst_n = 1'b0; sel = '0; auto_en = 1'b0; freeze_btn = 1'b1;
    ch_data = {$urandom, $urandom};
    model_reset();

    // Reset held with data toggling: outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      ch_data = {$urandom, $urandom};
      cycle();
    end
    check_eq("reset_seg", seg_n, {DIG*7{1'b1}});
    check_eq("reset_cur", cur_ch, 0);
    check_eq("reset_frz", frozen, 0);
    rst_n = 1'b1;
    cycle();
    check_eq("rel_seg_ch0", seg_n, ref_seg(ch_data[DW-1:0]));

    // Manual select of channel 2 = 1A8F.
    ch_data = {16'h5555, 16'h1A8F, 16'h0BCD, 16'h1234};
    sel = 2'd2;
    cycles(3);
    check_eq("manual_cur", cur_ch, 2);
    cycle();
    check_eq("manual_seg", seg_n, {7'h79, 7'h08, 7'h00, 7'h0E});

    // Auto scroll from channel 2; sel=1 waits while ignored.
    auto_en = 1'b1;
    sel = 2'd1;
    for (int g = 0; g < 4; g++) begin
      cycles(SC);
      check_eq("auto_seq", cur_ch, (3 + g) % NCH);
    end
    auto_en = 1'b0;
    cycle();
    check_eq("auto_exit", cur_ch, 1);

    // Freeze / debounce on channel 0 = 1234.
    sel = 2'd0;
    cycles(4);
    freeze_btn = 1'b0; cycles(3);
    freeze_btn = 1'b1; cycles(10);
    check_eq("glitch_nofrz", frozen, 0);
    freeze_btn = 1'b0; cycles(10);
    check_eq("press_frz", frozen, 1);
    freeze_btn = 1'b1;
    ch_data[DW-1:0] = 16'hFFFF;
    cycles(10);
    check_eq("frozen_seg", seg_n, {7'h79, 7'h24, 7'h30, 7'h19});
    check_eq("release_frz", frozen, 1);
    freeze_btn = 1'b0; cycles(10);
    freeze_btn = 1'b1; cycles(10);
    check_eq("unfrz", frozen, 0);
    check_eq("live_seg", seg_n, {4{7'h0E}});

    // Clamp on the three-channel instance.
    sel = 2'd3;
    cycles(3);
    check_eq("clamp_cur3", cur_ch3, 2);
    cycle();
    check_eq("clamp_seg3", seg_n3, ref_seg(ch_data[2*DW +: DW]));

    // Leading digits.
    sel = 2'd0;
    ch_data[DW-1:0] = 16'h0042;
    cycles(4);
    lead = LZB ? 7'h7F : 7'h40;
    check_eq("lzb_d3", seg_n[21 +: 7], lead);
    check_eq("lzb_d2", seg_n[14 +: 7], lead);
    check_eq("lzb_d1", seg_n[7 +: 7], 7'h19);
    ch_data[DW-1:0] = 16'h0000;
    cycle();
    check_eq("zero_seg", seg_n, {lead, lead, lead, 7'h40});

    // Randomised traffic against the model, with one asynchronous reset.
    btn_hold = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) ch_data = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) sel = CHW'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) auto_en = !auto_en;
      if (btn_hold == 0) begin
        freeze_btn = !freeze_btn;
        btn_hold = $urandom_range(1, 12);
      end else begin
        btn_hold--;
      end
      if (i == 400) mid_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
